// File: rtl/split_reg_if.sv
// rtl/split_reg_if.sv - native-bus bundle between the merge stage, split_reg and its slaves
//
// Purpose: groups the upstream request/response pair, the per-slave request/response
// vectors and the decode-error pulse of one split_reg instance.
// Signals:
//   m_req   REQ_W            {valid, address, wdata, wstrb} from the merge stage
//   m_resp  RESP_W           {rdata, ready} back to the merge stage
//   s_req   N_SLAVES*REQ_W   slot k = request to slave k
//   s_resp  N_SLAVES*RESP_W  slot k = response from slave k
//   err     1                one-cycle pulse on an unmapped access
// Modports:
//   slave   the split_reg side (consumes m_req / s_resp)
//   master  the environment side (merge stage plus slaves)
interface split_reg_if #(
    parameter int N_SLAVES = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    logic [REQ_W-1:0]           m_req;
    logic [RESP_W-1:0]          m_resp;
    logic [N_SLAVES*REQ_W-1:0]  s_req;
    logic [N_SLAVES*RESP_W-1:0] s_resp;
    logic                       err;

    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req,
        output err
    );

    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req,
        input  err
    );
endinterface

// File: rtl/split_reg.sv
// rtl/split_reg.sv - registered address-decoding demultiplexer for the native bus
//
// Purpose: takes the single request of the upstream merge stage, decodes the slave
// index from address[P_SLAVES -: clog2(N_SLAVES)], forwards a registered copy of the
// request to that slave, and returns the slave's rdata through a register. Indices
// >= N_SLAVES are answered locally with {rdata=0, ready=1} and an err pulse.
// One transaction is outstanding at a time.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-low reset
//   bus   split_reg_if.slave: m_req/m_resp (upstream), s_req/s_resp (slaves), err
module split_reg #(
    parameter int N_SLAVES = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int P_SLAVES = ADDR_W - 1
) (
    input  logic        clk,
    input  logic        rst,
    split_reg_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RESP_W = DATA_W + 1;
    localparam int SEL_W  = $clog2(N_SLAVES);

    // One extra bit so the "index < N_SLAVES" test also works when N_SLAVES is a
    // power of two (every index then maps).
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(N_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    // Upstream request fields.
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [SEL_W-1:0]  m_idx;
    logic              m_mapped;

    assign m_valid  = bus.m_req[REQ_W-1];
    assign m_addr   = bus.m_req[REQ_W-2 -: ADDR_W];
    assign m_wdata  = bus.m_req[STRB_W +: DATA_W];
    assign m_wstrb  = bus.m_req[STRB_W-1:0];
    assign m_idx    = m_addr[P_SLAVES -: SEL_W];
    assign m_mapped = ({1'b0, m_idx} < SEL_LIM);

    // Captured transaction.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] rdata_q;

    logic capture;
    logic load_rdata;

    // Response of the selected slave; every other slot's ready is ignored.
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_ready = bus.s_resp[k*RESP_W];
                sel_rdata = bus.s_resp[k*RESP_W+1 +: DATA_W];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        load_rdata = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (m_valid) begin
                    if (m_mapped) begin
                        capture   = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                if (sel_ready) begin
                    load_rdata = 1'b1;
                    state_nxt  = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state and registers only, so an asynchronous reset
    // clears them (including a slave valid mid-REQ) without waiting for a clock.
    logic [REQ_W-1:0]           req_word;
    logic [N_SLAVES*REQ_W-1:0]  s_req_c;
    logic [RESP_W-1:0]          m_resp_c;
    logic                       err_c;

    assign req_word = {1'b1, addr_q, wdata_q, wstrb_q};

    always_comb begin
        s_req_c  = '0;
        m_resp_c = '0;
        err_c    = 1'b0;
        unique case (state)
            ST_REQ: begin
                for (int k = 0; k < N_SLAVES; k++) begin
                    if (sel_q == SEL_W'(k)) begin
                        s_req_c[k*REQ_W +: REQ_W] = req_word;
                    end
                end
            end
            ST_RESP: m_resp_c = {rdata_q, 1'b1};
            ST_ERR: begin
                m_resp_c = {{DATA_W{1'b0}}, 1'b1};
                err_c    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.s_req  = s_req_c;
    assign bus.m_resp = m_resp_c;
    assign bus.err    = err_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                wstrb_q <= m_wstrb;
                sel_q   <= m_idx;
            end
            if (load_rdata) begin
                rdata_q <= sel_rdata;
            end
        end
    end
endmodule

// File: tb/tb_split_reg.sv
// tb/tb_split_reg.sv - self-checking bench for split_reg (2-slave and 3-slave instances)
module tb_split_reg;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RQ = 1 + AW + DW + DW / 8;
    localparam int RS = DW + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    split_reg_if #(.N_SLAVES(2), .DATA_W(DW), .ADDR_W(AW)) bus2 ();
    split_reg_if #(.N_SLAVES(3), .DATA_W(DW), .ADDR_W(AW)) bus3 ();

    split_reg #(.N_SLAVES(2), .DATA_W(DW), .ADDR_W(AW), .P_SLAVES(31)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    split_reg #(.N_SLAVES(3), .DATA_W(DW), .ADDR_W(AW), .P_SLAVES(31)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [RQ-1:0] mreq_v [2];
    logic [RS-1:0] sr     [2][3];

    assign bus2.m_req  = mreq_v[0];
    assign bus2.s_resp = {sr[0][1], sr[0][0]};
    assign bus3.m_req  = mreq_v[1];
    assign bus3.s_resp = {sr[1][2], sr[1][1], sr[1][0]};

    int checks = 0;
    int errors = 0;

    function automatic int nslv(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int idx_of(int d, logic [31:0] a);
        return (d == 0) ? int'(a[31]) : int'(a[31:30]);
    endfunction

    function automatic logic [RQ-1:0] obs_sreq(int d, int k);
        if (d == 0) return bus2.s_req[k*RQ +: RQ];
        return bus3.s_req[k*RQ +: RQ];
    endfunction

    function automatic logic [RS-1:0] obs_mresp(int d);
        return (d == 0) ? bus2.m_resp : bus3.m_resp;
    endfunction

    function automatic logic obs_err(int d);
        return (d == 0) ? bus2.err : bus3.err;
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // vslot < 0: no slave request expected.
    task automatic chk_out(input int d, input string tag, input int vslot,
                           input logic [RQ-1:0] vword, input logic [RS-1:0] mresp,
                           input logic e_err);
        for (int k = 0; k < nslv(d); k++) begin
            chk($sformatf("%s_d%0d_sreq%0d", tag, d, k), obs_sreq(d, k),
                (k == vslot) ? vword : '0);
        end
        chk($sformatf("%s_d%0d_mresp", tag, d), obs_mresp(d), mresp);
        chk($sformatf("%s_d%0d_err", tag, d), obs_err(d), e_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        for (int d = 0; d < 2; d++) begin
            mreq_v[d] = '0;
            for (int k = 0; k < 3; k++) sr[d][k] = '0;
        end
    endtask

    // One transaction observed at transaction level: cycle 0 request, slave valid
    // for cycles 1..1+wt (ready on the last), master ready in cycle 2+wt; unmapped
    // index answers in cycle 1. Returns at the start of the following IDLE cycle
    // with the request still presented, so the caller decides what comes next.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int wt, input logic [31:0] rd,
                       input bit spur, input string tag);
        int ix;
        int other;
        logic [RQ-1:0] w;
        ix = idx_of(d, a);
        w  = {1'b1, a, wd, ws};
        mreq_v[d]     = w;
        mreq_v[1 - d] = '0;
        for (int k = 0; k < 3; k++) sr[d][k] = {$urandom(), 1'b0};
        if (spur) begin
            other = (ix + 1) % nslv(d);
            sr[d][other][0] = 1'b1;
        end
        @(negedge clk);
        chk_out(d, {tag, "_c0"}, -1, '0, '0, 1'b0);
        cyc();
        if (ix >= nslv(d)) begin
            @(negedge clk);
            chk_out(d, {tag, "_decerr"}, -1, '0, {32'h0, 1'b1}, 1'b1);
            cyc();
            return;
        end
        for (int c = 1; c <= 1 + wt; c++) begin
            if (c == 1 + wt) sr[d][ix] = {rd, 1'b1};
            @(negedge clk);
            chk_out(d, $sformatf("%s_req_c%0d", tag, c), ix, w, '0, 1'b0);
            cyc();
        end
        sr[d][ix] = {$urandom(), 1'b0};
        @(negedge clk);
        chk_out(d, {tag, "_resp"}, -1, '0, {rd, 1'b1}, 1'b0);
        cyc();
    endtask

    task automatic idle_cycle(input int d, input string tag);
        mreq_v[d] = '0;
        @(negedge clk);
        chk_out(d, tag, -1, '0, '0, 1'b0);
        cyc();
    endtask

    initial begin
        logic [31:0] a;
        int d;
        rst = 1'b0;
        clr_inputs();

        // Reset held with random activity on every input.
        for (int i = 0; i < 4; i++) begin
            cyc();
            for (int dd = 0; dd < 2; dd++) begin
                mreq_v[dd] = {1'($urandom()), $urandom(), $urandom(), 4'($urandom())};
                for (int k = 0; k < 3; k++) sr[dd][k] = {$urandom(), 1'($urandom())};
            end
            @(negedge clk);
            chk_out(0, "reset", -1, '0, '0, 1'b0);
            chk_out(1, "reset", -1, '0, '0, 1'b0);
        end
        cyc();
        clr_inputs();
        rst = 1'b1;
        cyc();

        // Directed cases.
        txn(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'hCAFE_0001, 1'b0, "zw_write");
        idle_cycle(0, "zw_idle");
        txn(0, 32'h0000_0004, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0, "ws_read");
        idle_cycle(0, "ws_idle");
        txn(1, 32'hC000_0000, 32'h5555_AAAA, 4'h3, 0, 32'h0, 1'b1, "dec");
        idle_cycle(1, "dec_idle");

        // Back-to-back with a spurious ready on the non-selected slave.
        txn(0, 32'h0000_0100, 32'h1111_2222, 4'h1, 2, 32'hA5A5_0F0F, 1'b1, "b2b0");
        txn(0, 32'h8000_0200, 32'h3333_4444, 4'h0, 0, 32'h0BAD_F00D, 1'b1, "b2b1");
        idle_cycle(0, "b2b_idle");

        // Randomized traffic on both instances.
        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 1));
            a = $urandom();
            txn(d, a, $urandom(), 4'($urandom()), int'($urandom_range(0, 3)), $urandom(),
                1'($urandom()), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle_cycle(d, $sformatf("rnd%0d_idle", i));
        end
        mreq_v[0] = '0;
        mreq_v[1] = '0;
        cyc();

        // Reset asserted during cycle 2 of a wait-state access.
        clr_inputs();
        mreq_v[0] = {1'b1, 32'h0000_0010, 32'h7777_8888, 4'hF};
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk_out(0, "mid_c1", 0, {1'b1, 32'h0000_0010, 32'h7777_8888, 4'hF}, '0, 1'b0);
        cyc();
        #2;
        rst = 1'b0;
        #1;
        chk_out(0, "mid_async", -1, '0, '0, 1'b0);
        sr[0][0] = {32'h9999_0000, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk_out(0, $sformatf("mid_hold%0d", i), -1, '0, '0, 1'b0);
        end
        cyc();
        clr_inputs();
        rst = 1'b1;
        cyc();
        txn(0, 32'h8000_0040, 32'h0102_0304, 4'hC, 1, 32'h4433_2211, 1'b0, "post_rst");
        idle_cycle(0, "post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/split_reg.md
# split_reg

Registered address-decoding demultiplexer for the native bus. It sits directly downstream of the N-master `merge` stage and takes that stage's single slave-side request. It routes each transaction to one of `N_SLAVES` slaves, selected by an address bit field. The slave response is returned to the merge stage through a registered path, so both the request and the response are cut at a register boundary. Unmapped addresses are answered locally with a decode-error response.

## Interface
- `N_SLAVES`, 2, number of slave ports (≥2).
- `DATA_W`, 32, data width.
- `ADDR_W`, 32, address width.
- `P_SLAVES`, `ADDR_W-1`, MSB position of the slave-select field. Field width Nb = clog2(N_SLAVES); index = address[P_SLAVES -: Nb].
- Bus widths and field positions follow `interconnect.vh`:
  - REQ_W = 1 + ADDR_W + DATA_W + DATA_W/8 (valid, address, wdata, wstrb).
  - RESP_W = DATA_W + 1 (rdata, ready).

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low (asserted when 0).
- `m_req` in REQ_W: request from the upstream merge stage.
- `m_resp` out RESP_W: response to the upstream merge stage.
- `s_req` out N_SLAVES*REQ_W: slave requests; slot k carries the request for slave k.
- `s_resp` in N_SLAVES*RESP_W: slave responses.
- `err` out 1: one-cycle pulse on an unmapped access.

## Operation
- **Master protocol**
  - The master holds valid, address, wdata and wstrb stable until it samples ready=1.
  - In the cycle after ready, the master may drop valid or present a new request.
- **IDLE**
  - m_resp = 0, all s_req = 0, err = 0.
  - On m valid=1, mapped index (< N_SLAVES):
    - Capture address, wdata, wstrb and the index into registers.
    - Go to REQ.
  - On m valid=1, index ≥ N_SLAVES: go to ERR. Nothing is captured toward any slave.
- **REQ**
  - Drive s_req[sel] = {1, captured address (full, unmodified), wdata, wstrb}.
  - All other s_req slots = 0; m_resp = 0.
  - m_req is ignored in this state.
  - When s_resp[sel].ready=1:
    - Capture s_resp[sel].rdata.
    - Go to RESP.
  - Ready from any non-selected slave is ignored.
- **RESP**
  - m_resp = {captured rdata, ready=1} for exactly one cycle.
  - All s_req = 0.
  - Go to IDLE.
- **ERR**
  - m_resp = {rdata=0, ready=1} and err=1 for exactly one cycle.
  - All s_req = 0.
  - Go to IDLE.
- **General rules**
  - rdata is meaningful only when ready=1; m_resp.rdata = 0 whenever ready=0.
  - Exactly one transaction is outstanding at a time; there is no pipelining of requests.
  - Writes (wstrb≠0) and reads (wstrb=0) are handled identically.
  - For writes, rdata is whatever the slave returned.
- **Reset**
  - Asynchronous assertion forces state=IDLE, all registers to 0, and all outputs to 0 immediately.
  - This includes a reset mid-REQ: slave valid drops without waiting for ready.
  - A pending response is discarded and no ready is issued.
  - Deassertion takes effect at the next rising edge.

## Timing
- Cycle 0: m valid sampled high in IDLE.
- Cycle 1: s_req[sel].valid high.
  - If the slave returns ready in cycle 1 (zero-wait slave), m ready is high in cycle 2. Minimum latency is 2 cycles.
  - For a slave with wait states, s valid stays high from cycle 1 through the ready cycle r; m ready is high in cycle r+1.
  - s valid is low in cycle r+1.
- Decode error: valid in cycle 0 → m ready and err high in cycle 1.
- Back-to-back: the state is IDLE in the cycle after RESP/ERR, and a request present then is captured at that edge. With a zero-wait slave, the minimum spacing between transactions is 3 cycles.
- Valid held high in the RESP/ERR cycle is not re-captured; only the IDLE state samples m valid.

## Test plan
- **Reset:**
  - Hold rst=0 with random inputs → m_resp=0, s_req=0, err=0.
  - Release → first request is accepted normally.
- **Zero-wait write:**
  - Stimulus: N_SLAVES=2, address=0x8000_0010, wdata=0xDEADBEEF, wstrb=0xF, slave1 ready in the same cycle.
  - Required: s_req slot1 carries address 0x8000_0010 and wdata 0xDEADBEEF in cycle 1; slot0 = 0; m ready in cycle 2.
- **Wait-state read:**
  - Stimulus: address=0x0000_0004, wstrb=0, slave0 ready after 3 cycles with rdata=0x12345678.
  - Required: s valid high in cycles 1–4; m_resp = {0x12345678, 1} in cycle 5 only.
- **Decode error:**
  - Stimulus: N_SLAVES=3, P_SLAVES=31, address=0xC000_0000 (index 3).
  - Required: no s_req valid; m_resp = {0, 1} and err=1 in cycle 1; idle in cycle 2.
- **Back-to-back and spurious ready:**
  - Stimulus: slave0 transaction, then a slave1 transaction presented in the IDLE cycle after RESP; slave1 asserts ready during the slave0 transaction.
  - Required: slave0 completes unaffected; slave1 valid appears one cycle after capture.
- **Reset mid-REQ:**
  - Stimulus: assert rst during cycle 2 of a wait-state access.
  - Required: s valid drops combinationally; no m ready is ever issued; a new request after release completes correctly.
